// File: rtl/iter_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mdu_pkg
//  Description : Shared definitions for the iterative multiply-divide unit:
//                operation codes, FSM state encoding, divide-by-zero result
//                constant and small op-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int c_OP_CODE_W = 4;

    typedef enum logic [c_OP_CODE_W-1:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9,
        OP_NOP   = 4'd10
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Every LO bit takes this value on a divide by zero; HI returns in1.
    localparam logic c_DIV0_LO_FILL = 1'b1;

    function automatic logic op_is_mul(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_mdu_if.sv
`default_nettype none
// ============================================================================
//  Interface   : iter_mdu_if
//  Description : EX-stage bus of the multiply-divide unit.
//                master (pipeline): drives in1, in2, mdu_op, start, req
//                slave  (MDU)     : drives hi, lo, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface iter_mdu_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [OP_W-1:0]  mdu_op;
    logic             start;
    logic             req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output in1, in2, mdu_op, start, req,
        input  hi, lo, busy, done
    );

    modport slave (
        input  in1, in2, mdu_op, start, req,
        output hi, lo, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/iter_mdu_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_core
//  Description : Unsigned radix-2 shift-add multiplier / restoring divider
//                with its iteration counter. One step per i_step cycle.
//  Ports       : clk, rst_n (async, active low)
//                i_start  - load operands, counter = WIDTH-1
//                i_div    - mode latched at start (1 = divide)
//                i_step   - perform one iteration
//                i_a, i_b - magnitudes (multiplicand/multiplier or
//                           dividend/divisor)
//                o_last   - counter at zero (this step is the final one)
//                o_prod, o_quot, o_rem - results
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_start,
    input  wire logic               i_div,
    input  wire logic               i_step,
    input  wire logic [WIDTH-1:0]   i_a,
    input  wire logic [WIDTH-1:0]   i_b,
    output logic                    o_last,
    output logic [2*WIDTH-1:0]      o_prod,
    output logic [WIDTH-1:0]        o_quot,
    output logic [WIDTH-1:0]        o_rem
);
    localparam int c_CNT_W = $clog2(WIDTH);

    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_div;
    logic [WIDTH-1:0]    r_d;      // multiplicand (mul) or divisor (div)
    // Shared shift register. mul: {partial product, remaining multiplier}.
    // div: {partial remainder, dividend bits shifting out / quotient in}.
    logic [2*WIDTH-1:0]  r_p;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH+1:0]    w_diff;

    assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_d : {WIDTH{1'b0}})};
    assign w_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_d   <= '0;
            r_p   <= '0;
        end else if (i_start) begin
            r_cnt <= c_CNT_W'(WIDTH - 1);
            r_div <= i_div;
            r_d   <= i_div ? i_b : i_a;
            r_p   <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
        end else if (i_step) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_div) begin
                // Borrow out of the trial subtraction means restore.
                if (!w_diff[WIDTH+1]) begin
                    r_p <= {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
                end else begin
                    r_p <= {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_p <= {w_sum, r_p[WIDTH-1:1]};
            end
        end
    end

    assign o_last = (r_cnt == '0);
    assign o_prod = r_p;
    assign o_quot = r_p[WIDTH-1:0];
    assign o_rem  = r_p[2*WIDTH-1:WIDTH];
endmodule
`default_nettype wire

// File: rtl/iter_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : iter_mdu
//  Description : Iterative multiply-divide unit with HI/LO, multiply-
//                accumulate, defined divide-by-zero and exception abort.
//                Latency WIDTH+1 cycles from start to commit.
//  Ports       : clk   - clock
//                reset - asynchronous, active-low reset
//                bus   - iter_mdu_if.slave (in1, in2, mdu_op, start, req ->
//                        hi, lo, busy, done)
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    iter_mdu_if.slave   bus
);
    mdu_state_e          r_state;
    mdu_op_e             r_op;
    logic [WIDTH-1:0]    r_hi, r_lo, r_in1;
    logic [2*WIDTH-1:0]  r_base;
    logic                r_busy, r_done, r_neg_q, r_neg_a, r_div0;

    logic [OP_W-1:0]     w_op_raw;
    mdu_op_e             w_op;
    logic                w_is_mul, w_is_div, w_signed, w_launch, w_step;
    logic                w_neg_a, w_neg_b, w_last;
    logic [WIDTH-1:0]    w_mag_a, w_mag_b, w_quot, w_rem, w_quot_s, w_rem_s;
    logic [2*WIDTH-1:0]  w_prod, w_prod_s, w_res;

    assign w_op_raw = bus.mdu_op;
    assign w_op     = mdu_op_e'(c_OP_CODE_W'(w_op_raw));
    assign w_is_mul = op_is_mul(w_op);
    assign w_is_div = op_is_div(w_op);
    assign w_signed = op_is_signed(w_op);
    assign w_launch = (r_state == ST_IDLE) && !bus.req && bus.start && (w_is_mul || w_is_div);
    assign w_step   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && !bus.req;

    assign w_neg_a  = w_signed && bus.in1[WIDTH-1];
    assign w_neg_b  = w_signed && bus.in2[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -bus.in1 : bus.in1;
    assign w_mag_b  = w_neg_b ? -bus.in2 : bus.in2;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_launch),
        .i_div   (w_is_div),
        .i_step  (w_step),
        .i_a     (w_mag_a),
        .i_b     (w_mag_b),
        .o_last  (w_last),
        .o_prod  (w_prod),
        .o_quot  (w_quot),
        .o_rem   (w_rem)
    );

    // Sign fix-up: product/quotient negate on differing signs, remainder
    // follows the dividend. Most-negative / -1 wraps back to most-negative.
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot_s = r_neg_q ? -w_quot : w_quot;
    assign w_rem_s  = r_neg_a ? -w_rem  : w_rem;

    always_comb begin
        w_res = w_prod_s;
        case (r_op)
            OP_MADD, OP_MADDU: w_res = r_base + w_prod_s;
            OP_MSUB, OP_MSUBU: w_res = r_base - w_prod_s;
            OP_DIV,  OP_DIVU:  w_res = r_div0 ? {r_in1, {WIDTH{c_DIV0_LO_FILL}}}
                                              : {w_rem_s, w_quot_s};
            default:           w_res = w_prod_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_hi    <= '0;
            r_lo    <= '0;
            r_in1   <= '0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_a <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_op    <= w_op;
                        r_in1   <= bus.in1;
                        r_base  <= {r_hi, r_lo};
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_a <= w_neg_a;
                        r_div0  <= (bus.in2 == '0);
                        r_busy  <= 1'b1;
                        r_state <= w_is_div ? ST_DIV : ST_MUL;
                    end else if (!bus.req && (w_op == OP_MTHI)) begin
                        r_hi <= bus.in1;
                    end else if (!bus.req && (w_op == OP_MTLO)) begin
                        r_lo <= bus.in1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (bus.req) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // An abort arriving in the commit cycle still wins.
                    if (!bus.req) begin
                        r_hi   <= w_res[2*WIDTH-1:WIDTH];
                        r_lo   <= w_res[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_iter_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_mdu
//  Description : Self-checking bench for iter_mdu at WIDTH=32 (directed
//                vector table and corner sequences) and WIDTH=8 (random ops
//                against an arithmetic reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst32_n = 1'b0;
    logic rst8_n  = 1'b0;
    always #5 clk = ~clk;

    iter_mdu_if #(.WIDTH(32), .OP_W(4)) if32 ();
    iter_mdu_if #(.WIDTH(8),  .OP_W(4)) if8 ();

    iter_mdu #(.WIDTH(32), .OP_W(4)) u_dut32 (.clk(clk), .reset(rst32_n), .bus(if32));
    iter_mdu #(.WIDTH(8),  .OP_W(4)) u_dut8  (.clk(clk), .reset(rst8_n),  .bus(if8));

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    typedef struct {
        mdu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic drive(input bit s, input mdu_op_e op, input logic st, input logic rq,
                         input logic [31:0] a, input logic [31:0] b);
        if (s) begin
            if8.mdu_op = op; if8.start = st; if8.req = rq; if8.in1 = a[7:0]; if8.in2 = b[7:0];
        end else begin
            if32.mdu_op = op; if32.start = st; if32.req = rq; if32.in1 = a; if32.in2 = b;
        end
    endtask

    function automatic logic [31:0] get_hi(input bit s);
        return s ? {24'd0, if8.hi} : if32.hi;
    endfunction
    function automatic logic [31:0] get_lo(input bit s);
        return s ? {24'd0, if8.lo} : if32.lo;
    endfunction
    function automatic logic get_busy(input bit s);
        return s ? if8.busy : if32.busy;
    endfunction
    function automatic logic get_done(input bit s);
        return s ? if8.done : if32.done;
    endfunction

    function automatic longint sext(input logic [63:0] v, input int w);
        logic [63:0] t;
        t = v << (64 - w);
        return $signed(t) >>> (64 - w);
    endfunction

    // Architectural reference: plain *, /, % on sign-extended operands.
    function automatic void ref_model(input int w, input mdu_op_e op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] hi_in, input logic [31:0] lo_in,
                                      output logic [31:0] hi_o, output logic [31:0] lo_o);
        logic [63:0] m, ua, ub, base, res, ps, pu;
        longint sa, sb;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        sa   = sext(ua, w);
        sb   = sext(ub, w);
        base = (({32'd0, hi_in} & m) << w) | ({32'd0, lo_in} & m);
        ps   = 64'(sa * sb);
        pu   = ua * ub;
        res  = base;
        case (op)
            OP_MULT:  res = ps;
            OP_MULTU: res = pu;
            OP_MADD:  res = base + ps;
            OP_MADDU: res = base + pu;
            OP_MSUB:  res = base - ps;
            OP_MSUBU: res = base - pu;
            OP_DIV:   res = (ub == 0) ? ((ua << w) | m)
                                      : (((64'(sa % sb) & m) << w) | (64'(sa / sb) & m));
            OP_DIVU:  res = (ub == 0) ? ((ua << w) | m)
                                      : (((ua % ub) << w) | (ua / ub));
            OP_MTHI:  res = (ua << w) | (base & m);
            OP_MTLO:  res = (base & (m << w)) | ua;
            default:  res = base;
        endcase
        hi_o = 32'((res >> w) & m);
        lo_o = 32'(res & m);
    endfunction

    // Launch an arithmetic op, check latency, done pulse and hold of HI/LO.
    task automatic run_op(input bit s, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb,
                          output logic [31:0] hi_a, output logic [31:0] lo_a);
        int w = s ? 8 : 32;
        int cyc = 0;
        int early_done = 0;
        int hold_bad = 0;
        logic [31:0] ph, pl;
        ph = get_hi(s);
        pl = get_lo(s);
        drive(s, op, 1'b1, 1'b0, a, b);
        @(negedge clk);
        drive(s, OP_NOP, 1'b0, 1'b0, ~a, ~b);
        while (get_busy(s) && cyc < 200) begin
            cyc++;
            if (get_done(s)) early_done++;
            if (get_hi(s) !== ph || get_lo(s) !== pl) hold_bad++;
            if (disturb && cyc == 3) drive(s, OP_MTHI, 1'b1, 1'b0, $urandom, $urandom);
            if (disturb && cyc == 6) drive(s, OP_MULT, 1'b0, 1'b0, $urandom, $urandom);
            @(negedge clk);
        end
        drive(s, OP_NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        check("busy_len", 64'(cyc), 64'(w + 1));
        check("done_while_busy", 64'(early_done), 64'd0);
        check("hold_while_busy", 64'(hold_bad), 64'd0);
        check("done_pulse", {63'd0, get_done(s)}, 64'd1);
        hi_a = get_hi(s);
        lo_a = get_lo(s);
        @(negedge clk);
        check("done_single", {63'd0, get_done(s)}, 64'd0);
    endtask

    task automatic mt_op(input bit s, input mdu_op_e op, input logic [31:0] a, input logic rq,
                         output logic [31:0] hi_a, output logic [31:0] lo_a);
        drive(s, op, 1'b0, rq, a, 32'd0);
        @(negedge clk);
        drive(s, OP_NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        check("mt_busy", {63'd0, get_busy(s)}, 64'd0);
        check("mt_done", {63'd0, get_done(s)}, 64'd0);
        hi_a = get_hi(s);
        lo_a = get_lo(s);
    endtask

    // Start an op and raise req so it is sampled at edge n after the start edge.
    task automatic abort_at(input bit s, input mdu_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input int n);
        logic [31:0] ph, pl;
        ph = get_hi(s);
        pl = get_lo(s);
        drive(s, op, 1'b1, 1'b0, a, b);
        @(negedge clk);
        drive(s, OP_NOP, 1'b0, 1'b0, a, b);
        for (int i = 1; i < n; i++) @(negedge clk);
        check("abort_busy_before", {63'd0, get_busy(s)}, 64'd1);
        drive(s, OP_NOP, 1'b0, 1'b1, a, b);
        @(negedge clk);
        check("abort_busy_after", {63'd0, get_busy(s)}, 64'd0);
        check("abort_no_done", {63'd0, get_done(s)}, 64'd0);
        check("abort_hi", 64'(get_hi(s)), 64'(ph));
        check("abort_lo", 64'(get_lo(s)), 64'(pl));
        drive(s, OP_NOP, 1'b0, 1'b0, a, b);
        @(negedge clk);
        check("abort_no_done_later", {63'd0, get_done(s)}, 64'd0);
        check("abort_idle", {63'd0, get_busy(s)}, 64'd0);
    endtask

    // Model-checked op on either instance; keeps the expected HI/LO state.
    task automatic modeled(input bit s, input mdu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic rq, input bit disturb);
        logic [31:0] eh, el, ah, al;
        if (op == OP_MTHI || op == OP_MTLO) begin
            if (rq) begin
                eh = exp_hi[s]; el = exp_lo[s];
            end else begin
                ref_model(s ? 8 : 32, op, a, b, exp_hi[s], exp_lo[s], eh, el);
            end
            mt_op(s, op, a, rq, ah, al);
        end else begin
            ref_model(s ? 8 : 32, op, a, b, exp_hi[s], exp_lo[s], eh, el);
            run_op(s, op, a, b, disturb, ah, al);
        end
        check("model_hi", 64'(ah), 64'(eh));
        check("model_lo", 64'(al), 64'(el));
        exp_hi[s] = eh;
        exp_lo[s] = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ah, al, ra, rb;
        mdu_op_e rop;

        tbl[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{OP_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
        tbl[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[6] = '{OP_MTHI,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
        tbl[7] = '{OP_MTLO,  32'd1,         32'd0,        32'h1234_5678, 32'h0000_0001};
        tbl[8] = '{OP_MADDU, 32'hFFFF_FFFF, 32'd2,        32'h1234_5679, 32'hFFFF_FFFF};
        tbl[9] = '{OP_MSUB,  32'd1,         32'd1,        32'h1234_5679, 32'hFFFF_FFFE};

        drive(1'b0, OP_NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, OP_NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_hi",   64'(get_hi(s[0])), 64'd0);
            check("reset_lo",   64'(get_lo(s[0])), 64'd0);
            check("reset_busy", {63'd0, get_busy(s[0])}, 64'd0);
            check("reset_done", {63'd0, get_done(s[0])}, 64'd0);
        end
        rst32_n = 1'b1;
        rst8_n  = 1'b1;
        @(negedge clk);

        // Directed vector table (WIDTH=32), applied in order.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].op == OP_MTHI || tbl[i].op == OP_MTLO)
                mt_op(1'b0, tbl[i].op, tbl[i].a, 1'b0, ah, al);
            else
                run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, ah, al);
            check($sformatf("vec%0d_hi", i), 64'(ah), 64'(tbl[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(al), 64'(tbl[i].lo));
        end
        exp_hi[0] = 32'h1234_5679;
        exp_lo[0] = 32'hFFFF_FFFE;
        exp_hi[1] = 32'd0;
        exp_lo[1] = 32'd0;

        // Abort in MUL at cycle 10, then the same op restarted in full.
        abort_at(1'b0, OP_MULT, 32'd5, 32'd7, 10);
        modeled(1'b0, OP_MULT, 32'd5, 32'd7, 1'b0, 1'b0);
        check("restart_lo", 64'(if32.lo), 64'd35);

        // start/MTHI while busy plus operand changes are ignored.
        modeled(1'b0, OP_MULT, 32'h1000, 32'h10, 1'b0, 1'b1);
        check("disturb_lo", 64'(if32.lo), 64'h1_0000);
        // MTHI blocked by req in IDLE.
        modeled(1'b0, OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a divide.
        drive(1'b0, OP_DIV, 1'b1, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        check("rst_mid_busy_before", {63'd0, if32.busy}, 64'd1);
        #2 rst32_n = 1'b0;
        #1;
        check("rst_mid_hi",   64'(if32.hi), 64'd0);
        check("rst_mid_lo",   64'(if32.lo), 64'd0);
        check("rst_mid_busy", {63'd0, if32.busy}, 64'd0);
        @(negedge clk);
        rst32_n = 1'b1;
        exp_hi[0] = 32'd0;
        exp_lo[0] = 32'd0;
        @(negedge clk);
        check("rst_mid_done", {63'd0, if32.done}, 64'd0);
        modeled(1'b0, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);

        // WIDTH=8: abort in the commit cycle, then random ops vs model.
        modeled(1'b1, OP_MTLO, 32'h5A, 32'd0, 1'b0, 1'b0);
        abort_at(1'b1, OP_MULT, 32'd3, 32'd3, 9);
        for (int i = 0; i < 1000; i++) begin
            rop = mdu_op_e'(4'($urandom_range(0, 9)));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFF;
                2: ra = 32'h80;
                default: ;
            endcase
            modeled(1'b1, rop, ra, rb, ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
